// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 PS-side register bus: response codes,
// register address width and the AXI-Lite bridge FSM encoding.
package tlk2711_pkg;

    localparam int REG_ADDR_WIDTH = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full-word writes reach the register file; partial strobes are refused.
    localparam logic [7:0] WSTRB_FULL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_e;

endpackage

// File: rtl/tlk2711_axil_regbus_if.sv
// AXI4-Lite channel bundle between the PS master and the register-bus bridge.
interface tlk2711_axil_regbus_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 64
);
    logic                      s_axil_awvalid;
    logic                      s_axil_awready;
    logic [ADDR_WIDTH-1:0]     s_axil_awaddr;
    logic                      s_axil_wvalid;
    logic                      s_axil_wready;
    logic [DATA_WIDTH-1:0]     s_axil_wdata;
    logic [DATA_WIDTH/8-1:0]   s_axil_wstrb;
    logic                      s_axil_bvalid;
    logic                      s_axil_bready;
    logic [1:0]                s_axil_bresp;
    logic                      s_axil_arvalid;
    logic                      s_axil_arready;
    logic [ADDR_WIDTH-1:0]     s_axil_araddr;
    logic                      s_axil_rvalid;
    logic                      s_axil_rready;
    logic [DATA_WIDTH-1:0]     s_axil_rdata;
    logic [1:0]                s_axil_rresp;

    modport master (
        output s_axil_awvalid, s_axil_awaddr, s_axil_wvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_bready, s_axil_arvalid, s_axil_araddr, s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
               s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp
    );

    modport slave (
        input  s_axil_awvalid, s_axil_awaddr, s_axil_wvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_bready, s_axil_arvalid, s_axil_araddr, s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
               s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp
    );

endinterface

// File: rtl/tlk2711_axil_regbus.sv
// AXI4-Lite slave -> single-cycle register bus; one transaction in flight, writes win.
// Write strobe 1 cycle after AW+W, B the cycle after; read strobe 1 cycle after AR, R at 2+RD_LATENCY.
module tlk2711_axil_regbus
    import tlk2711_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 19,
    parameter int DATA_WIDTH      = 64,
    parameter int RD_LATENCY      = 1
) (
    input  logic                      ps_clk,
    input  logic                      ps_rst,
    tlk2711_axil_regbus_if.slave      axil,
    output logic                      o_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] o_reg_waddr,
    output logic [DATA_WIDTH-1:0]     o_reg_wdata,
    output logic                      o_reg_ren,
    output logic [REG_ADDR_WIDTH-1:0] o_reg_raddr,
    input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_e                      state_q, state_d;
    logic                        live_q;
    logic                        aw_held_q, aw_held_d;
    logic                        w_held_q, w_held_d;
    logic [REG_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]     wstrb_q, wstrb_d;
    logic [REG_ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic [1:0]                  bresp_q, bresp_d;

    logic aw_rdy, w_rdy, ar_rdy;
    logic aw_hs, w_hs, ar_hs;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{axil.s_axil_awaddr[2:0], axil.s_axil_araddr[2:0]};

    // live_q holds the readies low for the reset cycle itself.
    assign aw_rdy = live_q && (state_q == IDLE) && !aw_held_q;
    assign w_rdy  = live_q && (state_q == IDLE) && !w_held_q;
    assign ar_rdy = live_q && (state_q == IDLE) && !aw_held_q && !w_held_q
                    && !axil.s_axil_awvalid && !axil.s_axil_wvalid;

    assign aw_hs = axil.s_axil_awvalid && aw_rdy;
    assign w_hs  = axil.s_axil_wvalid  && w_rdy;
    assign ar_hs = axil.s_axil_arvalid && ar_rdy;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = axil.s_axil_awaddr[AXIL_ADDR_WIDTH-1:3];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = axil.s_axil_wdata;
                    wstrb_d  = axil.s_axil_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    state_d = WR_ISSUE;
                end else if (ar_hs) begin
                    raddr_d = axil.s_axil_araddr[AXIL_ADDR_WIDTH-1:3];
                    cnt_d   = 3'd0;
                    state_d = RD_WAIT;
                end
            end
            WR_ISSUE: begin
                bresp_d = (wstrb_q == WSTRB_FULL) ? RESP_OKAY : RESP_SLVERR;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (axil.s_axil_bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_WAIT: begin
                // cnt_q == 0 is the strobe cycle, so data is due when it reaches LAT.
                if (cnt_q == LAT) begin
                    rdata_d = i_reg_rdata;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD_RESP: begin
                if (axil.s_axil_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            raddr_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            raddr_q   <= raddr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
        end
    end

    assign axil.s_axil_awready = aw_rdy;
    assign axil.s_axil_wready  = w_rdy;
    assign axil.s_axil_arready = ar_rdy;
    assign axil.s_axil_bvalid  = (state_q == WR_RESP);
    assign axil.s_axil_bresp   = bresp_q;
    assign axil.s_axil_rvalid  = (state_q == RD_RESP);
    assign axil.s_axil_rdata   = rdata_q;
    assign axil.s_axil_rresp   = RESP_OKAY;

    assign o_reg_wen   = (state_q == WR_ISSUE) && (wstrb_q == WSTRB_FULL);
    assign o_reg_waddr = waddr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_ren   = (state_q == RD_WAIT) && (cnt_q == 3'd0);
    assign o_reg_raddr = raddr_q;

endmodule
